apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
Single-outstanding APB initiator that converts a valid/ready command channel into APB3 transfers, then returns read data and error status on a valid/ready response channel.
- Drives the psel/penable/paddr/pwrite/pwdata/pprot side of slave peripherals such as the timer block.
- Used by debug/DMA-style agents and by the verification harness to exercise APB slaves from RTL.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr and paddr
DATA_WIDTH, 32, width of write/read data
PPROT_VAL, 3'b010, constant driven on pprot during every transfer
TIMEOUT_CYCLES, 255, wait-state limit in ACCESS (used only with the optional feature)

Ports:
pclk  in  1  single clock for all logic
presetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  pslverr or timeout for this transfer
rsp_timeout  out  1  transfer was aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_WIDTH  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pprot  out  3  APB protection
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Clock and reset: one clock, pclk. Asynchronous, active-low reset presetn.
- Reset values: all outputs are 0 except cmd_ready = 1. The FSM resets to IDLE.
- Reset asserted mid-transfer: psel and penable drop immediately (asynchronously) and any pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On handshake, register cmd_write/cmd_addr/cmd_wdata into paddr/pwrite/pwdata, then go to SETUP.
  - For reads, pwdata is driven to 0.
- SETUP: psel = 1, penable = 0, for exactly one cycle, then go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1.
  - Stay while pready = 0.
  - On pready = 1: capture rsp_rdata (prdata for reads, 0 for writes) and rsp_err = pslverr; deassert psel and penable the next cycle; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata, rsp_err and rsp_timeout are held stable until rsp_ready.
  - On handshake: rsp_valid = 0, go to IDLE, cmd_ready = 1.
- cmd_ready is 0 in every state other than IDLE.
- No back-to-back pipelining: the minimum cadence is 4 cycles per transfer.
- Bus stability: paddr, pwrite, pwdata and pprot are stable from SETUP through the final ACCESS cycle.
  - After the transfer they hold their last values; psel = 0 qualifies them as idle.
- Latency with pready = 1 and rsp_ready = 1:
  - cmd handshake in cycle 0.
  - psel rises in cycle 1.
  - penable rises in cycle 2.
  - rsp_valid rises in cycle 3.
  - cmd_ready returns in cycle 4.
- pslverr is sampled only when pready = 1 in ACCESS; at all other times it is ignored.
- cmd_valid while busy is ignored; no command is lost because cmd_ready = 0.
- rsp_ready while rsp_valid = 0 has no effect.

Optional Feature:
Macro APB_MST_TIMEOUT_EN.
- Defined:
  - A wait counter (width sufficient for TIMEOUT_CYCLES) clears on entering ACCESS and increments on each ACCESS cycle with pready = 0.
  - When the count equals TIMEOUT_CYCLES and pready = 0, the transfer is aborted: psel and penable drop the next cycle, and the FSM goes to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If pready = 1 arrives in the same cycle the limit is reached, the normal completion wins.
- Undefined: no counter exists, ACCESS waits indefinitely, and rsp_timeout is tied to 0.

Test Plan:
1. Write: cmd addr 0x04, wdata 0x12345678, pready = 1 -> psel in cycle 1, penable in cycle 2 with paddr = 0x04 and pwrite = 1; rsp_valid in cycle 3 with rsp_err = 0, rsp_rdata = 0.
2. Read with 3 wait states: prdata = 0xDEADBEEF, pready low for 3 ACCESS cycles -> penable high for 4 cycles; rsp_rdata = 0xDEADBEEF.
3. Slave error: read with pslverr = 1 and pready = 1 -> rsp_err = 1; pslverr = 1 while pready = 0 does not complete the transfer.
4. Response backpressure: rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready = 0, and a new cmd_valid is not accepted until after the rsp handshake.
5. Reset mid-ACCESS: presetn low while penable = 1 -> psel, penable and rsp_valid = 0 asynchronously; cmd_ready = 1 after reset release.
6. With APB_MST_TIMEOUT_EN and TIMEOUT_CYCLES = 4: pready held low -> abort after the 5th ACCESS cycle with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Without the macro, the same stimulus keeps penable high indefinitely.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: bundles the command channel, response channel and APB3
// initiator signals of apb_cmd_master.
//   cmd_*  : valid/ready command channel (agent -> master)
//   rsp_*  : valid/ready response channel (master -> agent)
//   p*     : APB3 bus (master <-> slave peripheral)
// Modports:
//   master : view used by apb_cmd_master itself
//   slave  : view used by the agent/peripheral side (e.g. a testbench)
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output psel, penable, paddr, pwrite, pwdata, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  psel, penable, paddr, pwrite, pwdata, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB3 initiator. Accepts one command on
// the valid/ready command channel, runs one APB transfer (SETUP then ACCESS
// until pready) and returns read data / error on the response channel.
// Minimum cadence is 4 cycles per transfer; no pipelining.
// Ports:
//   pclk    : clock
//   presetn : asynchronous active-low reset
//   bus     : apb_cmd_master_if.master (command, response and APB signals)
// Optional feature: define APB_MST_TIMEOUT_EN to abort an ACCESS phase that
// sees pready low for more than TIMEOUT_CYCLES wait states; the response then
// reports rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Without the macro,
// ACCESS waits indefinitely and rsp_timeout is tied to 0.
module apb_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [2:0]  PPROT_VAL      = 3'b010,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  apb_cmd_master_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic                  pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic [2:0]            pprot_q,     pprot_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

`ifdef APB_MST_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt_q,    wait_cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pprot_d     = pprot_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MST_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
          pprot_d  = PPROT_VAL;
          state_d  = SETUP;
        end
      end
      SETUP: begin
`ifdef APB_MST_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = ACCESS;
      end
      ACCESS: begin
        // Completion takes priority over a timeout reached in the same cycle.
        if (bus.pready) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
`ifdef APB_MST_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d     = RESP;
        end
`ifdef APB_MST_TIMEOUT_EN
        else if (wait_cnt_q == CNT_LIMIT) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pprot_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pprot_q     <= pprot_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_MST_TIMEOUT_EN
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  // Strobes decode straight from the state register so reset drops them
  // asynchronously.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable   = (state_q == ACCESS);
  assign bus.rsp_valid = (state_q == RESP);

  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pprot     = pprot_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: self-checking bench for apb_cmd_master. A transfer-level
// reference model predicts, per command, the APB phase lengths and the
// response contents; the bench plays the APB slave and the agent, checking
// every cycle at the falling clock edge.
module tb_apb_cmd_master;
  localparam int         AW   = 32;
  localparam int         DW   = 32;
  localparam int         TO   = 4;
  localparam logic [2:0] PROT = 3'b010;
`ifdef APB_MST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  apb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_cmd_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .PPROT_VAL     (PROT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One complete transfer. Entered and left at a falling edge in IDLE.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] rdata, input int waits, input bit slverr, input int bp);
    bit            tmo;
    int            acc_cycles;
    logic [DW-1:0] exp_rd;
    bit            exp_err;
    // Reference model: a timeout happens only when the slave would need more
    // wait states than the limit allows.
    tmo        = TO_EN && (waits > TO);
    acc_cycles = tmo ? TO + 1 : waits + 1;
    exp_rd     = (wr || tmo) ? '0 : rdata;
    exp_err    = tmo || slverr;

    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_psel", bus.psel, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    @(negedge pclk);
    // SETUP: scramble the command inputs to prove the bus holds registered values.
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    chk("setup_psel", bus.psel, 1);
    chk("setup_penable", bus.penable, 0);
    chk("setup_cmd_ready", bus.cmd_ready, 0);
    chk("setup_paddr", bus.paddr, addr);
    chk("setup_pwrite", bus.pwrite, wr);
    chk("setup_pwdata", bus.pwdata, wr ? wdata : '0);
    chk("setup_pprot", bus.pprot, PROT);
    bus.pready  = 1'($urandom_range(0, 1));
    bus.pslverr = 1'($urandom_range(0, 1));
    bus.prdata  = $urandom;
    for (int k = 0; k < acc_cycles; k++) begin
      @(negedge pclk);
      chk("acc_psel", bus.psel, 1);
      chk("acc_penable", bus.penable, 1);
      chk("acc_paddr", bus.paddr, addr);
      chk("acc_pwrite", bus.pwrite, wr);
      chk("acc_pwdata", bus.pwdata, wr ? wdata : '0);
      chk("acc_rsp_valid", bus.rsp_valid, 0);
      if (k == waits) begin
        bus.pready  = 1'b1;
        bus.pslverr = slverr;
        bus.prdata  = rdata;
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = ~slverr;
        bus.prdata  = $urandom;
      end
    end
    @(negedge pclk);
    bus.pready  = 1'($urandom_range(0, 1));
    bus.pslverr = 1'($urandom_range(0, 1));
    bus.prdata  = $urandom;
    for (int b = 0; b <= bp; b++) begin
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_rdata", bus.rsp_rdata, exp_rd);
      chk("rsp_err", bus.rsp_err, exp_err);
      chk("rsp_timeout", bus.rsp_timeout, tmo);
      chk("rsp_cmd_ready", bus.cmd_ready, 0);
      chk("rsp_psel", bus.psel, 0);
      chk("rsp_penable", bus.penable, 0);
      chk("rsp_paddr_hold", bus.paddr, addr);
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.rsp_ready = (b == bp);
      @(negedge pclk);
    end
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_cmd_ready", bus.cmd_ready, 1);
    chk("post_psel", bus.psel, 0);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    presetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pprot", bus.pprot, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    presetn = 1'b1;
    @(negedge pclk);

    xfer(1'b1, 32'h04, 32'h12345678, 32'h0, 0, 1'b0, 0);
    xfer(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 1'b0, 0);
    xfer(1'b0, 32'h20, 32'h0, 32'hCAFE0001, 2, 1'b1, 0);
    xfer(1'b0, 32'h30, 32'h0, 32'h55AA55AA, 1, 1'b0, 5);
    xfer(1'b0, 32'h40, 32'h0, 32'h0BADF00D, TO, 1'b0, 0);
    xfer(1'b0, 32'h44, 32'h0, 32'h13579BDF, TO + 1, 1'b0, 1);
    xfer(1'b1, 32'h48, 32'hA5A5A5A5, 32'h0, 20, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge pclk);
    end

    // Reset in the middle of ACCESS.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h80;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    @(negedge pclk);
    chk("mid_penable", bus.penable, 1);
    #2 presetn = 1'b0;
    #1;
    chk("arst_psel", bus.psel, 0);
    chk("arst_penable", bus.penable, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rel_cmd_ready", bus.cmd_ready, 1);
    chk("rel_psel", bus.psel, 0);
    chk("rel_rsp_valid", bus.rsp_valid, 0);
    xfer(1'b0, 32'h84, 32'h0, 32'h600DCAFE, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
